l1_refill_responder: RTL and testbench

Backing-store responder on the L1 miss/refill interface. It accepts single-word read and write requests from the L1 controller over a valid/ready request channel, models fixed access latency, and returns data or write acknowledgements over a valid/ready response channel. One request is outstanding at a time; storage is word-addressed.

---
 rtl/l1_refill_responder_pkg.sv | 25 ++
 rtl/l1_refill_responder_mem_array.sv | 34 +++
 rtl/l1_refill_responder.sv | 137 +++++++++++++
 tb/tb_l1_refill_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1_refill_responder_pkg.sv
// Shared types for the L1 refill responder and its L1-side users.
// Latency: none; this file holds only types, constants and helpers.
// Backpressure: not applicable.
package mem_pkg;

  // Default geometry. Modules that take their own parameters use these
  // only as fallbacks.
  localparam int WORD_W        = 32;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_IDX_W    = $clog2(MEM_DEPTH_DEF);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of index bits needed to address a storage array of 'depth' words.
  function automatic int addr_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/l1_refill_responder_mem_array.sv
// Word storage: synchronous write, combinational read, async clear.
// Latency: a write lands at the clock edge; a read reflects the array at once.
// Backpressure: none; the owner decides when to write and what to read.
module mem_array
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we_i,
  input  logic [addr_idx_w(MEM_DEPTH)-1:0] waddr_i,
  input  logic [WORD_SIZE-1:0]             wdata_i,
  input  logic [addr_idx_w(MEM_DEPTH)-1:0] raddr_i,
  output logic [WORD_SIZE-1:0]             rdata_o
);

  logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];

  // Storage: cleared on reset, one word written per edge when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/l1_refill_responder.sv
// Backing-store responder: single-word reads/writes, one outstanding request.
// Latency: response valid LATENCY cycles after request acceptance.
// Backpressure: response held stable until resp_ready; no new request until then.
module l1_refill_responder
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 resp_we
);

  localparam int IDX_W = addr_idx_w(MEM_DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(MEM_DEPTH);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic                 resp_we_q, resp_we_d;

  logic                 accept;
  logic                 req_in_range;
  logic                 addr_in_range;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_rdata;

  // Ready depends on state only; forced low while reset is asserted.
  assign req_ready     = (state_q == IDLE) && !rst;
  assign accept        = req_valid && req_ready;
  // Full-width compares: high address bits never alias into the array.
  assign req_in_range  = (req_addr < DEPTH_W);
  assign addr_in_range = (addr_q < DEPTH_W);
  // Writes commit at the acceptance edge; out-of-range writes are dropped.
  assign mem_we        = accept && req_we && req_in_range;

  mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (req_addr[IDX_W-1:0]),
    .wdata_i (req_wdata),
    .raddr_i (addr_q[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // State, latched request and registered response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_we_q    <= resp_we_d;
    end
  end

  // Next-state: the counter is loaded with LATENCY and RESP is entered on
  // the edge where it reads 1, so resp_valid rises exactly LATENCY edges
  // after acceptance for every LATENCY >= 1.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_we_d    = resp_we_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          cnt_d   = CNT_W'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_we_d    = we_q;
          resp_err_d   = !addr_in_range;
          resp_rdata_d = (!we_q && addr_in_range) ? mem_rdata : '0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign resp_we    = resp_we_q;

endmodule

// File: tb/tb_l1_refill_responder.sv
// Bench for l1_refill_responder: LATENCY=4 and LATENCY=1 instances.
// Directed requests push expected responses; a monitor pops and compares.
// Response timing, backpressure hold and reset behaviour are checked inline.
module tb_l1_refill_responder;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        resp_we    [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  l1_refill_responder #(.WORD_SIZE(32), .MEM_DEPTH(256), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .resp_we(resp_we[0])
  );

  l1_refill_responder #(.WORD_SIZE(32), .MEM_DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .resp_we(resp_we[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(input int d, input logic we, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.we = we; e.err = err; e.rdata = rdata;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Monitor: inputs only change on negedges, so sampling just after one
  // sees exactly what the following posedge will see.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (resp_valid[d] && resp_ready[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_unexpected dut%0d: got response, expected none", d);
          end else begin
            exp_t e;
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("resp_we dut%0d", d),    {31'd0, resp_we[d]},  {31'd0, e.we});
            chk($sformatf("resp_err dut%0d", d),   {31'd0, resp_err[d]}, {31'd0, e.err});
            chk($sformatf("resp_rdata dut%0d", d), resp_rdata[d],        e.rdata);
          end
        end
      end
    end
  end

  // Issue one request, queue its expected response, check response latency.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    push_exp(d, we, exp_err, exp_rdata);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency dut%0d addr %h", d, addr), lat, exp_lat);
  endtask

  initial begin
    int n;
    int seen;
    int bad_v, bad_d, bad_r;
    int last;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; resp_ready[d] = 1'b1;
    end
    rst = 1'b1;
    #3;
    chk("req_ready_in_rst dut4", {31'd0, req_ready[0]}, 32'd0);
    chk("req_ready_in_rst dut1", {31'd0, req_ready[1]}, 32'd0);
    chk("resp_valid_in_rst", {31'd0, resp_valid[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", {31'd0, req_ready[0]}, 32'd1);
    chk("resp_valid_after_rst", {31'd0, resp_valid[0]}, 32'd0);
    chk("resp_rdata_after_rst", resp_rdata[0], 32'd0);

    // Basic read of cleared storage, then write and read back.
    do_req(0, 1'b0, 32'h5,  32'h0,         32'h0,         1'b0, 4);
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 4);
    do_req(0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 4);

    // Backpressure: hold resp_ready low for 6 cycles after resp_valid.
    @(negedge clk);
    resp_ready[0] = 1'b0;
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
    push_exp(0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 50) begin @(negedge clk); n++; end
    chk("bp_latency", n, 4);
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid[0] !== 1'b1) bad_v++;
      if (resp_rdata[0] !== 32'hDEAD_BEEF) bad_d++;
      if (req_ready[0] !== 1'b0) bad_r++;
    end
    chk("bp_valid_held", bad_v, 0);
    chk("bp_rdata_held", bad_d, 0);
    chk("bp_req_ready_low", bad_r, 0);
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_after", {31'd0, req_ready[0]}, 32'd1);
    chk("bp_valid_cleared", {31'd0, resp_valid[0]}, 32'd0);

    // Range boundaries: 255 is the last word; 256 and high bits are errors.
    do_req(0, 1'b1, 32'd256,       32'h1234_5678, 32'h0,         1'b1, 4);
    do_req(0, 1'b0, 32'd256,       32'h0,         32'h0,         1'b1, 4);
    do_req(0, 1'b0, 32'd0,         32'h0,         32'h0,         1'b0, 4);
    do_req(0, 1'b1, 32'd255,       32'hA5A5_5A5A, 32'h0,         1'b0, 4);
    do_req(0, 1'b0, 32'd255,       32'h0,         32'hA5A5_5A5A, 1'b0, 4);
    do_req(0, 1'b1, 32'h8000_0005, 32'h0BAD_F00D, 32'h0,         1'b1, 4);
    do_req(0, 1'b0, 32'h5,         32'h0,         32'h0,         1'b0, 4);

    // Reset while a read is waiting: its response must never appear.
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[0] = 32'h10; req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid[0]) seen++;
    end
    chk("no_resp_after_midop_rst", seen, 0);
    chk("req_ready_after_midop_rst", {31'd0, req_ready[0]}, 32'd1);
    do_req(0, 1'b0, 32'h10,  32'h0, 32'h0, 1'b0, 4);
    do_req(0, 1'b0, 32'd255, 32'h0, 32'h0, 1'b0, 4);

    // LATENCY=1 instance: single read, then continuous request stream.
    do_req(1, 1'b1, 32'h3, 32'hCAFE_0003, 32'h0,         1'b0, 1);
    do_req(1, 1'b0, 32'h3, 32'h0,         32'hCAFE_0003, 1'b0, 1);
    @(negedge clk);
    req_we[1] = 1'b0; req_addr[1] = 32'h3; req_valid[1] = 1'b1;
    last = -1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready[1]) begin
        push_exp(1, 1'b0, 1'b0, 32'hCAFE_0003);
        if (last >= 0) chk("l1_accept_gap", c - last, 3);
        last = c;
        n++;
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    chk("l1_accept_count", n, 7);
    repeat (5) @(negedge clk);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
